btn_press_classifier: RTL and testbench

Press-classification stage between the button debouncer and the 15-tap variable CS delay in the SPI pass-through design. It consumes the debounced, clk-synchronous button level and emits single-cycle command pulses. A short press produces one increment. Holding the button auto-repeats increments, and a very long hold produces one clear command that resets the delay length to zero.

---
 rtl/btn_press_classifier.sv | 115 +++++++++++
 tb/tb_btn_press_classifier.sv | 138 +++++++++++++
 2 files changed

// File: rtl/btn_press_classifier.sv
// Turns the debounced button level into one-cycle inc/clr commands:
// a short press gives one increment, a hold auto-repeats and a very long hold clears.
module btn_press_classifier #(
  parameter int DIV        = 50_000,
  parameter int HOLD_TICKS = 500,
  parameter int RPT_TICKS  = 150,
  parameter int CLR_TICKS  = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_level,
  output logic       inc_pulse,
  output logic       clr_pulse,
  output logic [1:0] state_o
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(CLR_TICKS + 1);
  localparam int RW = $clog2(RPT_TICKS + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, REPEAT = 2'd2, WAIT_REL = 2'd3} state_t;

  state_t        state, state_n;
  logic          btn_q, btn_q_n;
  logic [PW-1:0] pre, pre_n;
  logic [HW-1:0] hold, hold_n;
  logic [RW-1:0] rpt, rpt_n;
  logic          inc_n, clr_n;
  logic          tick;
  logic [HW:0]   hold_nx;
  logic [RW:0]   rpt_nx;

  assign tick    = (state != IDLE) && (pre == PW'(DIV - 1));
  // One extra bit so the +1 compare never wraps at the terminal count
  assign hold_nx = {1'b0, hold} + (HW + 1)'(1);
  assign rpt_nx  = {1'b0, rpt} + (RW + 1)'(1);
  assign state_o = state;

  always_comb begin
    state_n = state;
    btn_q_n = btn_level;
    pre_n   = pre;
    hold_n  = hold;
    rpt_n   = rpt;
    inc_n   = 1'b0;
    clr_n   = 1'b0;

    if (state == IDLE || tick) pre_n = '0;
    else                       pre_n = pre + PW'(1);

    case (state)
      IDLE: begin
        if (btn_level && !btn_q) begin
          state_n = PRESS;
          pre_n   = '0;
          hold_n  = '0;
        end
      end
      PRESS: begin
        // A release coincident with the hold boundary still counts as a short press
        if (!btn_level) begin
          state_n = IDLE;
          inc_n   = 1'b1;
        end else if (tick) begin
          hold_n = hold_nx[HW-1:0];
          if (hold_nx == (HW + 1)'(HOLD_TICKS)) begin
            state_n = REPEAT;
            inc_n   = 1'b1;
            rpt_n   = '0;
          end
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          state_n = IDLE;
        end else if (tick) begin
          hold_n = hold_nx[HW-1:0];
          if (hold_nx == (HW + 1)'(CLR_TICKS)) begin
            state_n = WAIT_REL;
            clr_n   = 1'b1;
          end else if (rpt_nx == (RW + 1)'(RPT_TICKS)) begin
            inc_n = 1'b1;
            rpt_n = '0;
          end else begin
            rpt_n = rpt_nx[RW-1:0];
          end
        end
      end
      WAIT_REL: begin
        if (!btn_level) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // btn_q resets high so a button held through reset must be re-pressed
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      btn_q     <= 1'b1;
      pre       <= '0;
      hold      <= '0;
      rpt       <= '0;
      inc_pulse <= 1'b0;
      clr_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      btn_q     <= btn_q_n;
      pre       <= pre_n;
      hold      <= hold_n;
      rpt       <= rpt_n;
      inc_pulse <= inc_n;
      clr_pulse <= clr_n;
    end
  end
endmodule

// File: tb/tb_btn_press_classifier.sv
// Randomized + directed bench: a timing-arithmetic reference model queues expected
// pulses; an independent negedge monitor pops and compares them against the DUT.
module tb_btn_press_classifier;
  localparam int DIV = 4, HOLD = 3, RPT = 2, CLR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_level = 1'b0;
  logic       inc_pulse, clr_pulse;
  logic [1:0] state_o;

  btn_press_classifier #(.DIV(DIV), .HOLD_TICKS(HOLD), .RPT_TICKS(RPT), .CLR_TICKS(CLR)) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .inc_pulse(inc_pulse), .clr_pulse(clr_pulse), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; bit clr;} ev_t;
  ev_t q[$];
  int  vectors = 0, miscompares = 0;
  int  n = 0;
  int  exp_state = 0;

  // Reference: press start edge e0 plus elapsed edges decide every outcome
  initial begin : model
    bit active, prev;
    int e0, el, k;
    ev_t ev;
    active = 0; prev = 1; e0 = 0;
    forever begin
      @(posedge clk);
      n = n + 1;
      if (rst) begin
        active = 0; prev = 1;
      end else begin
        if (!active) begin
          if (btn_level && !prev) begin active = 1; e0 = n; end
        end else begin
          el = n - e0;
          if (!btn_level) begin
            // ticks strictly before the release edge decide short vs long
            if ((el - 1) / DIV < HOLD) begin ev.cyc = n; ev.clr = 0; q.push_back(ev); end
            active = 0;
          end else if (el % DIV == 0) begin
            k = el / DIV;
            if (k == HOLD || (k > HOLD && k < CLR && (k - HOLD) % RPT == 0)) begin
              ev.cyc = n; ev.clr = 0; q.push_back(ev);
            end else if (k == CLR) begin
              ev.cyc = n; ev.clr = 1; q.push_back(ev);
            end
          end
        end
        prev = btn_level;
      end
      if (!active) exp_state = 0;
      else if (n - e0 < HOLD * DIV) exp_state = 1;
      else if (n - e0 < CLR * DIV) exp_state = 2;
      else exp_state = 3;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (n > 0) begin
        while (q.size() > 0 && q[0].cyc < n) begin
          vectors++; miscompares++;
          $display("FAIL missing_pulse cyc=%0d got none, expected %s", q[0].cyc, q[0].clr ? "clr" : "inc");
          void'(q.pop_front());
        end
        if (inc_pulse || clr_pulse) begin
          vectors++;
          if (inc_pulse && clr_pulse) begin
            miscompares++;
            $display("FAIL both_pulses cyc=%0d got inc=1 clr=1, expected at most one", n);
          end else if (q.size() == 0 || q[0].cyc != n || q[0].clr != clr_pulse) begin
            miscompares++;
            $display("FAIL unexpected_pulse cyc=%0d got inc=%0b clr=%0b, expected %s", n, inc_pulse,
                     clr_pulse, (q.size() > 0 && q[0].cyc == n) ? (q[0].clr ? "clr" : "inc") : "none");
          end else begin
            void'(q.pop_front());
          end
        end
        vectors++;
        if (int'(state_o) != exp_state) begin
          miscompares++;
          $display("FAIL state cyc=%0d got %0d, expected %0d", n, state_o, exp_state);
        end
      end
    end
  end

  task automatic step(input logic b, input logic r, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      btn_level = b; rst = r;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int hi, lo;
    @(negedge clk);
    step(0, 1, 3);
    // short press
    step(0, 0, 2); step(1, 0, 5); step(0, 0, 5);
    // full hold through clear
    step(1, 0, 40); step(0, 0, 5);
    // release coincident with the hold boundary
    step(1, 0, 12); step(0, 0, 5);
    // held across reset, then a fresh press
    step(1, 1, 3); step(1, 0, 50); step(0, 0, 3); step(1, 0, 3); step(0, 0, 5);
    // reset mid-repeat with the button still held
    step(1, 0, 16); step(1, 1, 1); step(1, 0, 10); step(0, 0, 3); step(1, 0, 2); step(0, 0, 4);
    // back-to-back short presses
    for (int i = 0; i < 3; i++) begin step(1, 0, 2); step(0, 0, 1); end
    step(0, 0, 4);
    // randomized presses, occasionally interrupted by reset
    for (int i = 0; i < 80; i++) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) begin
        step(1, 0, hi / 2 + 1); step($urandom_range(0, 1) != 0, 1, 1); step(1, 0, hi / 2);
      end else begin
        step(1, 0, hi);
      end
      step(0, 0, lo);
    end
    step(0, 0, 6);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
